// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mux: PS/2 scancodes, joystick bit
// positions, key-slot indices and the coin pulse FSM states.
package arcade_input_pkg;

    // Joystick bit positions within each player's 16-bit word
    localparam int J_R     = 0;
    localparam int J_L     = 1;
    localparam int J_D     = 2;
    localparam int J_U     = 3;
    localparam int J_FIRE  = 4;
    localparam int J_START = 5;
    localparam int J_AUTO  = 6;
    localparam int J_COIN  = 7;

    // Scancodes ({extended, code})
    localparam logic [8:0] SC_P1_U      = 9'h175;
    localparam logic [8:0] SC_P1_D      = 9'h172;
    localparam logic [8:0] SC_P1_L      = 9'h16B;
    localparam logic [8:0] SC_P1_R      = 9'h174;
    localparam logic [8:0] SC_P1_SPACE  = 9'h029;
    localparam logic [8:0] SC_P1_CTRL   = 9'h014;
    localparam logic [8:0] SC_P2_U      = 9'h02D;
    localparam logic [8:0] SC_P2_D      = 9'h02B;
    localparam logic [8:0] SC_P2_L      = 9'h023;
    localparam logic [8:0] SC_P2_R      = 9'h034;
    localparam logic [8:0] SC_P2_FIRE   = 9'h01C;
    localparam logic [8:0] SC_START1    = 9'h016;
    localparam logic [8:0] SC_START1_F1 = 9'h005;
    localparam logic [8:0] SC_START2    = 9'h01E;
    localparam logic [8:0] SC_START2_F2 = 9'h006;
    localparam logic [8:0] SC_COIN_5    = 9'h02E;
    localparam logic [8:0] SC_COIN_6    = 9'h036;

    // One latched state bit per scancode so two keys sharing a function
    // release independently. Arrows come first.
    localparam int NUM_KEYS   = 17;
    localparam int NUM_ARROWS = 4;
    localparam int K_P1_U = 0,  K_P1_D = 1,  K_P1_L = 2,  K_P1_R = 3;
    localparam int K_P1_SPACE = 4, K_P1_CTRL = 5;
    localparam int K_P2_U = 6,  K_P2_D = 7,  K_P2_L = 8,  K_P2_R = 9;
    localparam int K_P2_FIRE = 10;
    localparam int K_START1 = 11, K_START1_F1 = 12;
    localparam int K_START2 = 13, K_START2_F2 = 14;
    localparam int K_COIN_5 = 15, K_COIN_6 = 16;

    localparam logic [8:0] KEY_CODES [NUM_KEYS] = '{
        SC_P1_U, SC_P1_D, SC_P1_L, SC_P1_R, SC_P1_SPACE, SC_P1_CTRL,
        SC_P2_U, SC_P2_D, SC_P2_L, SC_P2_R, SC_P2_FIRE,
        SC_START1, SC_START1_F1, SC_START2, SC_START2_F2,
        SC_COIN_5, SC_COIN_6
    };

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_WAIT_REL
    } coin_state_t;

    // Arrows also answer to their non-extended keypad twins (075 == 175)
    function automatic logic [NUM_KEYS-1:0] key_match(input logic [8:0] code);
        logic [NUM_KEYS-1:0] hit;
        for (int i = 0; i < NUM_KEYS; i++)
            hit[i] = (i < NUM_ARROWS) ? (code[7:0] == KEY_CODES[i][7:0])
                                      : (code == KEY_CODES[i]);
        return hit;
    endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// Coin pulse generator: one CYC-cycle active-low pulse per request, then
// waits for the request to drop before it can fire again.
module arcade_coin_pulse
    import arcade_input_pkg::*;
#(
    parameter int CYC = 120000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req,
    output logic pulse_n
);
    localparam int CW = $clog2(CYC + 1);

    coin_state_t   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          req_q, pulse_nx;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= COIN_IDLE;
            cnt     <= '0;
            req_q   <= 1'b0;
            pulse_n <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            req_q   <= req;
            pulse_n <= pulse_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pulse_nx = pulse_n;
        case (state)
            COIN_IDLE: begin
                if (req && !req_q) begin
                    state_nx = COIN_PULSE;
                    cnt_nx   = '0;
                    pulse_nx = 1'b0;
                end
            end
            COIN_PULSE: begin
                if (cnt == CW'(CYC - 1)) begin
                    state_nx = COIN_WAIT_REL;
                    cnt_nx   = '0;
                    pulse_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            COIN_WAIT_REL: begin
                if (!req)
                    state_nx = COIN_IDLE;
            end
            default: begin
                state_nx = COIN_IDLE;
                pulse_nx = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/arcade_input_mux.sv
// Arcade control mux: PS/2 keys and per-player joysticks to registered
// active-low cabinet inputs plus a fixed-width coin pulse.
// Define AUTOFIRE_EN to make joy bit 6 an autofire button.
module arcade_input_mux
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int COIN_CYC     = 120000,
    parameter int AUTOFIRE_DIV = 400000
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [10:0]               ps2_key,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    input  logic                      rotate,
    input  logic                      clear_keys,
    output logic [4*NUM_PLAYERS-1:0]  dir_n,
    output logic [NUM_PLAYERS-1:0]    fire_n,
    output logic [NUM_PLAYERS-1:0]    start_n,
    output logic                      coin_n
);
    logic                tog_q, hist_ok, key_evt;
    logic [NUM_KEYS-1:0] keys, hit;

    assign hit     = key_match(ps2_key[8:0]);
    assign key_evt = hist_ok && (ps2_key[10] != tog_q);

    // hist_ok gates the first post-reset cycle so the toggle history is
    // loaded from the live input instead of producing a phantom event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            hist_ok <= 1'b0;
            keys    <= '0;
        end else begin
            tog_q   <= ps2_key[10];
            hist_ok <= 1'b1;
            if (clear_keys)
                keys <= '0;
            else if (key_evt)
                keys <= (keys & ~hit) | (hit & {NUM_KEYS{ps2_key[9]}});
        end
    end

    // Keyboard contribution per player, {R,L,D,U}; players 3..4 have none
    logic [3:0][3:0] kdir;
    logic [3:0]      kfire, kstart;

    always_comb begin
        kdir      = '0;
        kfire     = '0;
        kstart    = '0;
        kdir[0]   = {keys[K_P1_R], keys[K_P1_L], keys[K_P1_D], keys[K_P1_U]};
        kdir[1]   = {keys[K_P2_R], keys[K_P2_L], keys[K_P2_D], keys[K_P2_U]};
        kfire[0]  = keys[K_P1_SPACE] | keys[K_P1_CTRL];
        kfire[1]  = keys[K_P2_FIRE];
        kstart[0] = keys[K_START1] | keys[K_START1_F1];
        kstart[1] = keys[K_START2] | keys[K_START2_F2];
    end

    logic [4*NUM_PLAYERS-1:0] dir_nx;
    logic [NUM_PLAYERS-1:0]   fire_nx, start_nx, coin_joy, af;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic u, d, l, r;
        assign u = kdir[p][0] | joy[16*p + J_U];
        assign d = kdir[p][1] | joy[16*p + J_D];
        assign l = kdir[p][2] | joy[16*p + J_L];
        assign r = kdir[p][3] | joy[16*p + J_R];

        // Rotated cabinet: U<-L, D<-R, L<-D, R<-U
        assign dir_nx[4*p +: 4] = rotate ? ~{u, d, r, l} : ~{r, l, d, u};
        assign fire_nx[p]  = ~(kfire[p] | joy[16*p + J_FIRE] | af[p]);
        assign start_nx[p] = ~(kstart[p] | joy[16*p + J_START]);
        assign coin_joy[p] = joy[16*p + J_COIN]
                           | (joy[16*p + J_START] & joy[16*p + J_FIRE]);

`ifdef AUTOFIRE_EN
        localparam int AW = $clog2(AUTOFIRE_DIV + 1);
        logic [AW-1:0] af_cnt;
        logic          af_ph;

        // Phase idles high so a fresh press fires at once
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                af_cnt <= '0;
                af_ph  <= 1'b1;
            end else if (!joy[16*p + J_AUTO]) begin
                af_cnt <= '0;
                af_ph  <= 1'b1;
            end else if (af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
                af_cnt <= '0;
                af_ph  <= ~af_ph;
            end else begin
                af_cnt <= af_cnt + AW'(1);
            end
        end
        assign af[p] = joy[16*p + J_AUTO] & af_ph;
`else
        assign af[p] = 1'b0;
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_n   <= '1;
            fire_n  <= '1;
            start_n <= '1;
        end else begin
            dir_n   <= dir_nx;
            fire_n  <= fire_nx;
            start_n <= start_nx;
        end
    end

    arcade_coin_pulse #(
        .CYC(COIN_CYC)
    ) u_coin (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .req    (keys[K_COIN_5] | keys[K_COIN_6] | (|coin_joy)),
        .pulse_n(coin_n)
    );

    logic unused_ok;
    assign unused_ok = ^{joy, kdir, kfire, kstart, (AUTOFIRE_DIV > 0)};

endmodule

// File: tb/tb_arcade_input_mux.sv
// Bench for arcade_input_mux: vector table, directed corner sequences and a
// randomized run against a key-set / countdown reference model.
module tb_arcade_input_mux;
    localparam int NP  = 4;
    localparam int CYC = 8;
    localparam int DIV = 4;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [10:0]       ps2_key = '0;
    logic [16*NP-1:0]  joy = '0;
    logic              rotate = 1'b0;
    logic              clear_keys = 1'b0;
    logic [4*NP-1:0]   dir_n;
    logic [NP-1:0]     fire_n, start_n;
    logic              coin_n;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mux #(
        .NUM_PLAYERS (NP),
        .COIN_CYC    (CYC),
        .AUTOFIRE_DIV(DIV)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joy       (joy),
        .rotate    (rotate),
        .clear_keys(clear_keys),
        .dir_n     (dir_n),
        .fire_n    (fire_n),
        .start_n   (start_n),
        .coin_n    (coin_n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic check_idle(input string name);
        check({name, "_dir"},   dir_n,   16'hFFFF);
        check({name, "_fire"},  fire_n,  4'hF);
        check({name, "_start"}, start_n, 4'hF);
        check({name, "_coin"},  coin_n,  1'b1);
    endtask

    // ---------------- reference model ----------------
    bit          pressed [512];
    bit          m_tog, m_hist, c_wait;
    int          c_left;
    int          af_h [NP];
    logic [4*NP-1:0] e_dir;
    logic [NP-1:0]   e_fire, e_start;
    logic            e_coin;

    task automatic model_reset();
        for (int i = 0; i < 512; i++) pressed[i] = 1'b0;
        m_tog = 1'b0; m_hist = 1'b0; c_wait = 1'b0; c_left = 0;
        for (int p = 0; p < NP; p++) af_h[p] = 0;
    endtask

    // Called once per clock edge with the inputs the DUT just sampled
    task automatic model_step();
        bit u, d, l, r, f, s, req;
        logic [7:0] jp;
        logic [8:0] code;
        req = pressed[9'h02E] | pressed[9'h036];
        for (int p = 0; p < NP; p++) begin
            jp = joy[16*p +: 8];
            r = jp[0]; l = jp[1]; d = jp[2]; u = jp[3]; f = jp[4]; s = jp[5];
            if (p == 0) begin
                u |= pressed[9'h075]; d |= pressed[9'h072];
                l |= pressed[9'h06B]; r |= pressed[9'h074];
                f |= pressed[9'h029] | pressed[9'h014];
                s |= pressed[9'h016] | pressed[9'h005];
            end else if (p == 1) begin
                u |= pressed[9'h02D]; d |= pressed[9'h02B];
                l |= pressed[9'h023]; r |= pressed[9'h034];
                f |= pressed[9'h01C];
                s |= pressed[9'h01E] | pressed[9'h006];
            end
`ifdef AUTOFIRE_EN
            if (jp[6]) af_h[p]++; else af_h[p] = 0;
            if (jp[6] && (((af_h[p] - 1) / DIV) % 2 == 0)) f = 1'b1;
`endif
            if (rotate) e_dir[4*p +: 4] = ~{u, d, r, l};
            else        e_dir[4*p +: 4] = ~{r, l, d, u};
            e_fire[p]  = ~f;
            e_start[p] = ~s;
            req |= jp[7] | (jp[5] & jp[4]);
        end
        if (c_left > 0) c_left--;
        else if (c_wait) begin if (!req) c_wait = 1'b0; end
        else if (req) begin c_left = CYC; c_wait = 1'b1; end
        e_coin = (c_left == 0);

        code = ps2_key[8:0];
        if (code[7:0] inside {8'h75, 8'h72, 8'h6B, 8'h74}) code[8] = 1'b0;
        if (clear_keys) for (int i = 0; i < 512; i++) pressed[i] = 1'b0;
        else if (m_hist && ps2_key[10] != m_tog) pressed[code] = ps2_key[9];
        m_tog  = ps2_key[10];
        m_hist = 1'b1;
    endtask

    logic [8:0] codes [25] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h175, 9'h172, 9'h16B,
                               9'h174, 9'h029, 9'h014, 9'h02D, 9'h02B, 9'h023, 9'h034,
                               9'h01C, 9'h016, 9'h005, 9'h01E, 9'h006, 9'h02E, 9'h036,
                               9'h01A, 9'h115, 9'h0FF, 9'h129};

    task automatic rand_inputs();
        if ($urandom_range(3) == 0) key($urandom_range(4) < 3, codes[$urandom_range(24)]);
        for (int p = 0; p < NP; p++) begin
            if ($urandom_range(3) == 0) begin
                for (int b = 0; b < 7; b++) joy[16*p + b] = ($urandom_range(5) == 0);
                joy[16*p + 7] = ($urandom_range(19) == 0);
                joy[16*p + 8 +: 8] = 8'($urandom);
            end
        end
        if ($urandom_range(49) == 0) rotate = ~rotate;
        clear_keys = ($urandom_range(39) == 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rot;
        logic [7:0] j;
        logic [3:0] dir;
        logic       fire;
        logic       start;
    } vec_t;
    vec_t vt [12];

    initial begin
        int lows, pulses;
        logic prev;
        int pl;

        vt[0]  = '{1'b0, 8'h00, 4'hF, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 8'h01, 4'h7, 1'b1, 1'b1};
        vt[2]  = '{1'b0, 8'h08, 4'hE, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 8'h02, 4'hB, 1'b1, 1'b1};
        vt[4]  = '{1'b0, 8'h04, 4'hD, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 8'h02, 4'hE, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 8'h01, 4'hD, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 8'h04, 4'hB, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 8'h08, 4'h7, 1'b1, 1'b1};
        vt[9]  = '{1'b1, 8'h0A, 4'h6, 1'b1, 1'b1};
        vt[10] = '{1'b0, 8'h10, 4'hF, 1'b0, 1'b1};
        vt[11] = '{1'b0, 8'h20, 4'hF, 1'b1, 1'b0};

        repeat (3) @(posedge clk_sys);
        #1;
        check_idle("reset");
        reset_n = 1'b1;
        tick();

        // joystick table on a keyboard player and a joy-only player
        for (int k = 0; k < 2; k++) begin
            pl = (k == 0) ? 0 : 3;
            for (int i = 0; i < 12; i++) begin
                joy = '0;
                joy[16*pl +: 8] = vt[i].j;
                rotate = vt[i].rot;
                tick();
                check($sformatf("vec%0d_p%0d_dir", i, pl), dir_n[4*pl +: 4], vt[i].dir);
                check($sformatf("vec%0d_p%0d_fire", i, pl), fire_n[pl], vt[i].fire);
                check($sformatf("vec%0d_p%0d_start", i, pl), start_n[pl], vt[i].start);
            end
        end
        joy = '0; rotate = 1'b0;
        tick();

        // key toggle latency, plain and extended up-arrow
        key(1'b1, 9'h075); tick();
        check("key_up_lat1", dir_n[0], 1'b1);
        tick();
        check("key_up_press", dir_n[0], 1'b0);
        key(1'b0, 9'h075); tick(); tick();
        check("key_up_release", dir_n[0], 1'b1);
        key(1'b1, 9'h175); tick(); tick();
        check("key_ext_up_press", dir_n[0], 1'b0);
        key(1'b0, 9'h175); tick(); tick();
        check("key_ext_up_release", dir_n[0], 1'b1);

        key(1'b1, 9'h01A); tick(); tick();
        check_idle("unmapped");
        key(1'b0, 9'h01A); tick();

        // clear_keys wins over a simultaneous press
        key(1'b1, 9'h029); tick(); tick();
        check("space_fire", fire_n[0], 1'b0);
        key(1'b1, 9'h014); clear_keys = 1'b1; tick();
        clear_keys = 1'b0; tick();
        check("clear_fire", fire_n[0], 1'b1);
        tick();
        check("clear_fire_hold", fire_n[0], 1'b1);

        // coin key held 20 cycles: one 8-cycle pulse
        key(1'b1, 9'h02E);
        lows = 0; pulses = 0; prev = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) check("coin_key_lat1", coin_n, 1'b1);
            if (i == 1) check("coin_key_lat2", coin_n, 1'b0);
            if (!coin_n) lows++;
            if (prev && !coin_n) pulses++;
            prev = coin_n;
        end
        check("coin_hold_lows", lows, 8);
        check("coin_hold_pulses", pulses, 1);
        key(1'b0, 9'h02E); tick(); tick(); tick();
        check("coin_released", coin_n, 1'b1);
        key(1'b1, 9'h02E);
        lows = 0; pulses = 0; prev = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!coin_n) lows++;
            if (prev && !coin_n) pulses++;
            prev = coin_n;
        end
        check("coin_repress_lows", lows, 8);
        check("coin_repress_pulses", pulses, 1);
        key(1'b0, 9'h02E); tick(); tick(); tick();

        // P2 start+fire combo: coin pulse and start_n together
        joy[16 + 4] = 1'b1; joy[16 + 5] = 1'b1;
        tick();
        check("combo_start", start_n[1], 1'b0);
        check("combo_coin", coin_n, 1'b0);
        lows = 1; pulses = 1; prev = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (!coin_n) lows++;
            if (prev && !coin_n) pulses++;
            prev = coin_n;
        end
        check("combo_lows", lows, 8);
        check("combo_pulses", pulses, 1);
        check("combo_start_held", start_n[1], 1'b0);
        joy = '0; tick(); tick(); tick();

        // autofire button on P1
        joy[6] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
`ifdef AUTOFIRE_EN
            check($sformatf("autofire_t%0d", i), fire_n[0], (((i - 1) / DIV) % 2 == 0) ? 1'b0 : 1'b1);
`else
            check($sformatf("autofire_off_t%0d", i), fire_n[0], 1'b1);
`endif
        end
        joy = '0; tick();

        // reset mid-pulse, and toggle history reload on release
        joy[7] = 1'b1;
        tick(); tick(); tick();
        check("pulse_cycle3", coin_n, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_pulse_coin", coin_n, 1'b1);
        joy = '0;
        key(1'b1, 9'h075);
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        check_idle("post_reset");

        // randomized run against the model
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            tick();
            model_step();
            check("rnd_dir",   dir_n,   e_dir);
            check("rnd_fire",  fire_n,  e_fire);
            check("rnd_start", start_n, e_start);
            check("rnd_coin",  coin_n,  e_coin);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
